// File: rtl/seq_mul.sv
// seq_mul: sequential radix-2 shift-add multiplier, one multiplier bit per cycle.
//
// Operands are captured on start while idle. Signed operands are reduced to
// magnitudes at capture. The magnitude product is built over WIDTH cycles, and
// the sign is applied as the result is written to y.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start        begin a multiply (only honoured in idle)
//   signed_mode  treat a/b as two's complement (gated by SIGNED_EN)
//   a, b         WIDTH-bit operands, sampled with start
//   busy         high while calculating or presenting a result
//   done         one-cycle pulse, y holds a fresh product
//   y            2*WIDTH-bit product, held until the next result
module seq_mul #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] y
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic                 neg_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   y_q;

    logic                 eff_mode;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is
    // exactly right when read back as unsigned.
    always_comb begin
        eff_mode = signed_mode & SIGNED_EN;
        a_neg    = eff_mode & a[WIDTH-1];
        b_neg    = eff_mode & b[WIDTH-1];
        a_mag    = a_neg ? (WIDTH'(0) - a) : a;
        b_mag    = b_neg ? (WIDTH'(0) - b) : b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                        mplier_q <= b_mag;
                        acc_q    <= '0;
                        neg_q    <= a_neg ^ b_neg;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    if (cnt_q == CW'(WIDTH)) begin
                        // All bits consumed: apply sign and publish on entry to DONE.
                        y_q     <= neg_q ? (2*WIDTH)'(0) - acc_q : acc_q;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        if (mplier_q[0]) begin
                            acc_q <= acc_q + mcand_q;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;

endmodule

// File: doc/seq_mul.md
SEQ_MUL -- requirements
Module: seq_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have parameter SIGNED_EN, default 1, 1 enables the signed_mode input; 0 forces unsigned operation.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-006 SHALL have port signed_mode  input  1  1 treats a and b as two's complement; sampled with start.
REQ-007 SHALL have port a  input  WIDTH  multiplicand; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  multiplier; sampled with start.
REQ-009 SHALL have port busy  output  1  high while in CALC or DONE.
REQ-010 SHALL have port done  output  1  single-cycle pulse marking y valid for a new result.
REQ-011 SHALL have port y  output  2*WIDTH  product; holds the last result until the next result is written.

Function
REQ-012 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-013 IDLE: start=1 at a rising edge SHALL capture a, b and the effective mode, then go to CALC; start=0 SHALL keep the FSM in IDLE.
REQ-014 Effective mode SHALL be signed_mode & SIGNED_EN.
REQ-015 CALC SHALL perform radix-2 shift-add with one multiplier bit per cycle, LSB first, for exactly WIDTH cycles using an internal bit counter, then go to DONE.
REQ-016 Signed mode: operands SHALL be converted to WIDTH-bit magnitudes at capture, the result sign SHALL be a[MSB] XOR b[MSB], and the magnitude product SHALL be negated in 2*WIDTH bits when the sign is 1.
REQ-017 The magnitude of -2^(WIDTH-1) SHALL be represented as unsigned 2^(WIDTH-1) with no overflow.
REQ-018 DONE SHALL last one cycle: y is updated with the full product, done=1, and the FSM returns to IDLE on the next edge.
REQ-019 Latency: start accepted at edge k SHALL give done=1 and a valid y in the cycle after edge k+WIDTH+1, so the result takes WIDTH+2 cycles from start to done.
REQ-020 start asserted while busy=1 SHALL be ignored, with no queueing and no change to the operation in progress.
REQ-021 start held high continuously SHALL give back-to-back operations with one IDLE cycle between done and the next capture.
REQ-022 Changes on a, b or signed_mode after capture SHALL NOT affect the operation in progress.
REQ-023 y SHALL change only in DONE and SHALL NOT expose intermediate partial products.
REQ-024 Unsigned results SHALL be exact for all 2^(2*WIDTH) operand pairs; signed results SHALL be exact two's-complement products, with no truncation and no saturation.
REQ-025 A zero operand SHALL still take the full WIDTH+2 cycles, with no early termination.

Reset
REQ-026 While rst=1 at a rising edge: state=IDLE, busy=0, done=0, y=0, bit counter=0, and captured operands cleared.
REQ-027 rst SHALL take priority over start and over every FSM transition.
REQ-028 rst asserted in the middle of CALC SHALL abort the operation with no done pulse, and y SHALL be 0.
REQ-029 The first start SHALL be accepted at the first edge with rst=0.

Verification (WIDTH=8, SIGNED_EN=1)
REQ-030 Unsigned: a=15, b=15, signed_mode=0, start pulse -> done after 10 cycles, y=225 (0x00E1); also a=255, b=255 -> y=0xFE01.
REQ-031 Signed corners: a=0x80, b=0x80 -> y=0x4000; a=0x80, b=0x7F -> y=0xC080; a=0xFF (-1), b=0x05 -> y=0xFFFB; with SIGNED_EN=0 and signed_mode=1, a=0xFF, b=0x05 -> y=0x04FB.
REQ-032 Busy rejection: start at cycle 0 (a=3, b=4), then a second start at cycle 3 with a=9, b=9 -> exactly one done pulse, y=12, and the second start is dropped.
REQ-033 Reset mid-operation: start with a=200, b=200, rst=1 at cycle 4 -> no done pulse, y=0, busy=0; a new start after rst deasserts completes normally.
REQ-034 Back-to-back: start held high with operands changed each result -> done pulses spaced 11 cycles apart, and every y matches the reference model.
REQ-035 Random regression: at least 10k random pairs in both modes, checked by a scoreboard against a*b computed in 2*WIDTH bits, plus an exhaustive sweep for WIDTH=4 in both modes.
